// File: rtl/i3c_ddr_rx_pkg.sv
// i3c_ddr_rx_pkg: HDR-DDR receive mode encodings, bit lengths and state type
package i3c_ddr_rx_pkg;
    typedef enum logic [3:0] {
        MODE_PREAMBLE     = 4'b0000,
        MODE_DESER_BYTE   = 4'b0011,
        MODE_CHECK_PARITY = 4'b0110,
        MODE_CRC_TOKEN    = 4'b0111,
        MODE_CRC_VALUE    = 4'b1000
    } rx_mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} rx_state_e;
    localparam logic [3:0] CRC_TOKEN    = 4'hC;
    localparam logic [3:0] LEN_PREAMBLE = 4'd1;
    localparam logic [3:0] LEN_BYTE     = 4'd8;
    localparam logic [3:0] LEN_PARITY   = 4'd2;
    localparam logic [3:0] LEN_TOKEN    = 4'd4;
    localparam logic [3:0] LEN_CRC      = 4'd5;
    function automatic logic mode_valid(input logic [3:0] m);
        return m inside {MODE_PREAMBLE, MODE_DESER_BYTE, MODE_CHECK_PARITY, MODE_CRC_TOKEN, MODE_CRC_VALUE};
    endfunction
    function automatic logic [3:0] mode_len(input logic [3:0] m);
        return m == MODE_PREAMBLE     ? LEN_PREAMBLE :
               m == MODE_DESER_BYTE   ? LEN_BYTE     :
               m == MODE_CHECK_PARITY ? LEN_PARITY   :
               m == MODE_CRC_TOKEN    ? LEN_TOKEN    : LEN_CRC;
    endfunction
endpackage

// File: rtl/i3c_ddr_rx_shift_reg.sv
// i3c_ddr_rx_shift_reg: MSB-first shift register with edge counter and terminal-count detect
module i3c_ddr_rx_shift_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       sample,
    input  logic       sda,
    input  logic [3:0] len,
    output logic [7:0] shift_nxt,
    output logic       last
);
    logic [6:0] shift;
    logic [3:0] cnt;
    assign shift_nxt = {shift, sda};
    assign last = sample && (cnt == len - 4'd1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (clr) begin
            shift <= '0;
            cnt   <= '0;
        end else if (sample) begin
            shift <= shift_nxt[6:0];
            cnt   <= cnt + 4'd1;
        end
    end
endmodule

// File: rtl/i3c_ddr_rx.sv
// i3c_ddr_rx: HDR-DDR receiver sampling SDA on both SCL edges, with preamble, byte, parity and CRC checks
module i3c_ddr_rx
    import i3c_ddr_rx_pkg::*;
(
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_sclgen_scl,
    input  logic       i_sclgen_scl_pos_edge,
    input  logic       i_sclgen_scl_neg_edge,
    input  logic       i_ddrccc_rx_en,
    input  logic       i_sdahnd_rx_sda,
    input  logic [4:0] i_bitcnt_rx_bit_count,
    input  logic [3:0] i_ddrccc_rx_mode,
    input  logic [4:0] i_crc_value,
    input  logic       i_crc_valid,
    output logic [7:0] o_regfcrc_rx_data_out,
    output logic       o_ddrccc_rx_mode_done,
    output logic       o_ddrccc_pre,
    output logic       o_ddrccc_error,
    output logic       o_crc_en
);
    rx_state_e   state, state_nxt;
    logic [3:0]  cur_mode;
    logic [7:0]  shift_nxt;
    logic [15:0] word;
    logic        sda, mode_ok, mode_chg, sample, last, enter_run, fail, unused_ok;
    assign sda       = i_sdahnd_rx_sda !== 1'b0;
    assign mode_ok   = mode_valid(i_ddrccc_rx_mode);
    assign mode_chg  = i_ddrccc_rx_mode != cur_mode;
    assign sample    = state == ST_RUN && i_ddrccc_rx_en && !mode_chg && (i_sclgen_scl_pos_edge || i_sclgen_scl_neg_edge);
    assign o_crc_en  = sample && cur_mode == MODE_DESER_BYTE;
    assign o_ddrccc_rx_mode_done = state == ST_DONE;
    assign unused_ok = ^{i_sclgen_scl, i_bitcnt_rx_bit_count};
    i3c_ddr_rx_shift_reg u_shift (
        .clk       (i_sys_clk),
        .rst       (i_sys_rst),
        .clr       (state != ST_RUN || mode_chg),
        .sample    (sample),
        .sda       (sda),
        .len       (mode_len(cur_mode)),
        .shift_nxt (shift_nxt),
        .last      (last)
    );
    always_comb begin
        state_nxt = !i_ddrccc_rx_en || !mode_ok ? ST_IDLE :
                    state == ST_RUN && !mode_chg ? (last ? ST_DONE : ST_RUN) : ST_RUN;
        enter_run = state_nxt == ST_RUN && (state != ST_RUN || mode_chg);
        fail      = cur_mode == MODE_CHECK_PARITY ? shift_nxt[1:0] != {^(word & 16'hAAAA), ~^(word & 16'h5555)} :
                    cur_mode == MODE_CRC_TOKEN    ? shift_nxt[3:0] != CRC_TOKEN :
                    cur_mode == MODE_CRC_VALUE && i_crc_valid && shift_nxt[4:0] != i_crc_value;
    end
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state                 <= ST_IDLE;
            cur_mode              <= '0;
            word                  <= '0;
            o_regfcrc_rx_data_out <= '0;
            o_ddrccc_pre          <= 1'b1;
            o_ddrccc_error        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enter_run)
                cur_mode <= i_ddrccc_rx_mode;
            if (last && cur_mode == MODE_PREAMBLE)
                o_ddrccc_pre <= sda;
            if (last && cur_mode == MODE_DESER_BYTE) begin
                o_regfcrc_rx_data_out <= shift_nxt;
                word                  <= {word[7:0], shift_nxt};
            end
            if (!i_ddrccc_rx_en || (enter_run && (i_ddrccc_rx_mode == MODE_PREAMBLE || i_ddrccc_rx_mode == MODE_DESER_BYTE)))
                o_ddrccc_error <= 1'b0;
            else if (last && fail)
                o_ddrccc_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i3c_ddr_rx.sv
// tb_i3c_ddr_rx: directed self-checking bench for the HDR-DDR receiver
module tb_i3c_ddr_rx;
    import i3c_ddr_rx_pkg::*;
    logic       clk = 0, rst = 1, scl = 1, pos = 0, neg = 0, en = 0, sda = 1, crc_valid = 0;
    logic [4:0] bitcnt = 0, crc_value = 0;
    logic [3:0] mode = 4'hF;
    logic [7:0] data_out;
    logic       done, pre, err, crc_en;
    int checks = 0, errors = 0, done_cnt = 0, crc_cnt = 0, d0, c0;
    i3c_ddr_rx dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst),
        .i_sclgen_scl          (scl),
        .i_sclgen_scl_pos_edge (pos),
        .i_sclgen_scl_neg_edge (neg),
        .i_ddrccc_rx_en        (en),
        .i_sdahnd_rx_sda       (sda),
        .i_bitcnt_rx_bit_count (bitcnt),
        .i_ddrccc_rx_mode      (mode),
        .i_crc_value           (crc_value),
        .i_crc_valid           (crc_valid),
        .o_regfcrc_rx_data_out (data_out),
        .o_ddrccc_rx_mode_done (done),
        .o_ddrccc_pre          (pre),
        .o_ddrccc_error        (err),
        .o_crc_en              (crc_en)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (crc_en === 1'b1) crc_cnt <= crc_cnt + 1;
    end
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic b, input logic [1:0] k);
        @(posedge clk); #1;
        sda = b; pos = k[0]; neg = k[1];
        @(posedge clk); #1;
        pos = 0; neg = 0;
    endtask
    task automatic run(input logic [3:0] m, input logic [7:0] bits, input int n, input int both);
        mode = m; en = 1;
        for (int i = n - 1; i >= 0; i--)
            send(bits[i], i == both ? 2'b11 : (i % 2 == 1 ? 2'b10 : 2'b01));
    endtask
    task automatic stop();
        en = 0; mode = 4'hF;
        @(posedge clk); #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_pre", pre, 1);
        chk("rst_err", err, 0);
        chk("rst_crc_en", crc_en, 0);
        d0 = done_cnt;
        run(MODE_PREAMBLE, 8'h00, 1, -1);
        chk("pre0", pre, 0);
        chk("pre0_done", done, 1);
        stop();
        chk("pre0_done_cnt", 16'(done_cnt - d0), 1);
        chk("done_low", done, 0);
        run(MODE_PREAMBLE, 8'h01, 1, -1);
        chk("pre1", pre, 1);
        stop();
        d0 = done_cnt; c0 = crc_cnt;
        run(MODE_DESER_BYTE, 8'hAD, 8, -1);
        chk("byte_ad", data_out, 8'hAD);
        chk("byte_ad_err", err, 0);
        stop();
        chk("byte_ad_crc_en", 16'(crc_cnt - c0), 8);
        chk("byte_ad_done_cnt", 16'(done_cnt - d0), 1);
        c0 = crc_cnt;
        run(MODE_DESER_BYTE, 8'hCA, 8, 3);
        chk("byte_ca", data_out, 8'hCA);
        stop();
        chk("byte_ca_crc_en", 16'(crc_cnt - c0), 8);
        c0 = crc_cnt;
        run(MODE_CHECK_PARITY, 8'h00, 2, -1);
        chk("par_ok_err", err, 0);
        chk("par_ok_done", done, 1);
        stop();
        run(MODE_CHECK_PARITY, 8'h02, 2, -1);
        chk("par_10_err", err, 1);
        stop();
        chk("err_clr_en", err, 0);
        chk("data_hold", data_out, 8'hCA);
        run(MODE_CHECK_PARITY, 8'h03, 2, -1);
        chk("par_11_err", err, 1);
        stop();
        chk("par_no_crc_en", 16'(crc_cnt - c0), 0);
        run(MODE_CRC_TOKEN, 8'h0C, 4, -1);
        chk("tok_ok_err", err, 0);
        stop();
        run(MODE_CRC_TOKEN, 8'h0A, 4, -1);
        chk("tok_bad_err", err, 1);
        stop();
        crc_valid = 1; crc_value = 5'h13;
        run(MODE_CRC_VALUE, 8'h13, 5, -1);
        chk("crc_ok_err", err, 0);
        stop();
        run(MODE_CRC_VALUE, 8'h12, 5, -1);
        chk("crc_bad_err", err, 1);
        stop();
        crc_valid = 0;
        run(MODE_CRC_VALUE, 8'h12, 5, -1);
        chk("crc_nocheck_err", err, 0);
        stop();
        d0 = done_cnt; c0 = crc_cnt;
        run(4'b0001, 8'h02, 2, -1);
        stop();
        chk("bad_mode_done", 16'(done_cnt - d0), 0);
        chk("bad_mode_crc_en", 16'(crc_cnt - c0), 0);
        d0 = done_cnt;
        run(MODE_DESER_BYTE, 8'h07, 3, -1);
        mode = MODE_PREAMBLE;
        @(posedge clk); #1;
        run(MODE_DESER_BYTE, 8'h5A, 8, -1);
        chk("restart_byte", data_out, 8'h5A);
        stop();
        chk("restart_done_cnt", 16'(done_cnt - d0), 1);
        chk("restart_pre", pre, 1);
        run(MODE_PREAMBLE, 8'h00, 1, -1);
        stop();
        run(MODE_DESER_BYTE, 8'h0F, 4, -1);
        rst = 1;
        #1;
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_pre", pre, 1);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_crc_en", crc_en, 0);
        @(posedge clk); #1;
        rst = 0;
        run(MODE_DESER_BYTE, 8'hCA, 8, -1);
        chk("post_rst_byte", data_out, 8'hCA);
        stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
